// File: rtl/control_pkg.sv
// Opcodes, state encoding and IR field layout shared by control_sequencer.
// Opcodes 0x12/0x13 decode as I/O instructions only when SEQ_IO_INSTR_EN is defined.
package control_pkg;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_SHR  = 5'h04;
    localparam logic [4:0] OP_SHRA = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_ROR  = 5'h07;
    localparam logic [4:0] OP_ROL  = 5'h08;
    localparam logic [4:0] OP_ADDI = 5'h09;
    localparam logic [4:0] OP_ANDI = 5'h0A;
    localparam logic [4:0] OP_ORI  = 5'h0B;
    localparam logic [4:0] OP_MUL  = 5'h0C;
    localparam logic [4:0] OP_DIV  = 5'h0D;
    localparam logic [4:0] OP_NEG  = 5'h0E;
    localparam logic [4:0] OP_NOT  = 5'h0F;
    localparam logic [4:0] OP_LD   = 5'h10;
    localparam logic [4:0] OP_ST   = 5'h11;
    localparam logic [4:0] OP_IN   = 5'h12;
    localparam logic [4:0] OP_OUT  = 5'h13;
    localparam logic [4:0] OP_NOP  = 5'h1A;
    localparam logic [4:0] OP_HALT = 5'h1B;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_E0    = 4'd5,
        ST_E1    = 4'd6,
        ST_E2    = 4'd7,
        ST_E3    = 4'd8,
        ST_E4    = 4'd9,
        ST_HALT  = 4'd10,
        ST_FAULT = 4'd11
    } state_e;

    typedef enum logic [3:0] {
        CL_RTYPE   = 4'd0,
        CL_IMM     = 4'd1,
        CL_UNARY   = 4'd2,
        CL_MULDIV  = 4'd3,
        CL_LD      = 4'd4,
        CL_ST      = 4'd5,
        CL_IN      = 4'd6,
        CL_OUT     = 4'd7,
        CL_NOP     = 4'd8,
        CL_HALT    = 4'd9,
        CL_ILLEGAL = 4'd10
    } op_class_e;

    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:       cls = CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:              cls = CL_IMM;
            OP_MUL, OP_DIV:                        cls = CL_MULDIV;
            OP_NEG, OP_NOT:                        cls = CL_UNARY;
            OP_LD:                                 cls = CL_LD;
            OP_ST:                                 cls = CL_ST;
`ifdef SEQ_IO_INSTR_EN
            OP_IN:                                 cls = CL_IN;
            OP_OUT:                                cls = CL_OUT;
`endif
            OP_NOP:                                cls = CL_NOP;
            OP_HALT:                               cls = CL_HALT;
            default:                               cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_sequencer_checker.sv
// Property checks on control_sequencer outputs: bus drivers never collide.
module control_sequencer_checker (
    input logic        clock,
    input logic        clear,
    input logic [24:0] bus_sel_i
);

    a_bus_onehot: assert property (@(posedge clock) disable iff (clear) $onehot0(bus_sel_i))
        else $error("control_sequencer: more than one bus source selected (%b)", bus_sel_i);

endmodule

// File: rtl/control_sequencer_reg_select_decoder.sv
// 4-bit register field to 16-bit one-hot select, gated by an enable.
module reg_select_decoder (
    input  logic [3:0]  sel_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);

    // One-hot expansion of the selected register number
    always_comb begin
        onehot_o = 16'h0000;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end else begin
            onehot_o = 16'h0000;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch / decode / execute sequencing for the bus datapath.
// Optional I/O instructions (in/out, OutPortin port) are enabled by defining SEQ_IO_INSTR_EN.
module control_sequencer
    import control_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int OPW          = 5
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    IR,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           Yout,
    output logic           InPortout,
    output logic           CSignOut,
    output logic [15:0]    Rout,
    output logic [15:0]    Rin,
    output logic           MARin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           ZHighIn,
    output logic           ZLowIn,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
`ifdef SEQ_IO_INSTR_EN
    output logic           OutPortin,
`endif
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           illegal
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    op_class_e         cls_s;
    logic [4:0]        opcode_s;
    logic [3:0]        ra_s, rb_s, rc_s;
    logic [3:0]        rout_sel_s;
    logic              rout_en_s;
    logic              rin_en_s;
    logic [4:0]        alu_s;
    logic              wait_state_s;
    logic              wait_limit_s;
    logic              unused_ir_s;

    assign opcode_s    = IR[IR_OP_MSB:IR_OP_LSB];
    assign ra_s        = IR[IR_RA_MSB:IR_RA_LSB];
    assign rb_s        = IR[IR_RB_MSB:IR_RB_LSB];
    assign rc_s        = IR[IR_RC_MSB:IR_RC_LSB];
    assign unused_ir_s = ^IR[IR_RC_LSB-1:0];
    assign cls_s       = op_class(opcode_s);

    // Memory handshake states: fetch read, ld read, st write
    assign wait_state_s = (state_q == ST_T1)
                        | ((state_q == ST_E3) & (cls_s == CL_LD))
                        | ((state_q == ST_E4) & (cls_s == CL_ST));
    assign wait_limit_s = (wait_cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

    // State and wait-counter registers with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= ST_RESET;
            wait_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic; the counter is zero whenever a wait is not in progress
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = {CNT_W{1'b0}};
        if (wait_state_s && !mem_ready) begin
            if (wait_limit_s) begin
                state_d = ST_FAULT;
            end else begin
                state_d    = state_q;
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_RESET: state_d = ST_T0;
                ST_T0:    state_d = ST_T1;
                ST_T1:    state_d = ST_T2;
                ST_T2:    state_d = ST_T3;
                ST_T3: begin
                    case (cls_s)
                        CL_NOP, CL_ILLEGAL: state_d = ST_T0;
                        CL_HALT:            state_d = ST_HALT;
                        default:            state_d = ST_E0;
                    endcase
                end
                ST_E0:    state_d = ((cls_s == CL_IN) || (cls_s == CL_OUT)) ? ST_T0 : ST_E1;
                ST_E1:    state_d = (cls_s == CL_UNARY) ? ST_T0 : ST_E2;
                ST_E2:    state_d = ((cls_s == CL_RTYPE) || (cls_s == CL_IMM)) ? ST_T0 : ST_E3;
                ST_E3:    state_d = (cls_s == CL_MULDIV) ? ST_T0 : ST_E4;
                ST_E4:    state_d = ST_T0;
                ST_HALT:  state_d = ST_HALT;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_FAULT;
            endcase
        end
    end

    // Moore control outputs decoded from state and instruction class
    always_comb begin
        PCout      = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        Yout       = 1'b0;
        InPortout  = 1'b0;
        CSignOut   = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        ZHighIn    = 1'b0;
        ZLowIn     = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Write      = 1'b0;
`ifdef SEQ_IO_INSTR_EN
        OutPortin  = 1'b0;
`endif
        illegal    = 1'b0;
        rout_sel_s = ra_s;
        rout_en_s  = 1'b0;
        rin_en_s   = 1'b0;
        alu_s      = 5'h00;
        run        = (state_q != ST_RESET) && (state_q != ST_HALT) && (state_q != ST_FAULT);
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: illegal = (cls_s == CL_ILLEGAL);
            ST_E0: begin
                case (cls_s)
                    CL_RTYPE, CL_IMM, CL_LD, CL_ST: begin
                        rout_sel_s = rb_s;
                        rout_en_s  = 1'b1;
                        Yin        = 1'b1;
                    end
                    CL_MULDIV: begin
                        rout_sel_s = ra_s;
                        rout_en_s  = 1'b1;
                        Yin        = 1'b1;
                    end
                    CL_UNARY: begin
                        rout_sel_s = rb_s;
                        rout_en_s  = 1'b1;
                        alu_s      = opcode_s;
                        ZLowIn     = 1'b1;
                    end
`ifdef SEQ_IO_INSTR_EN
                    CL_IN: begin
                        InPortout = 1'b1;
                        rin_en_s  = 1'b1;
                    end
                    CL_OUT: begin
                        rout_sel_s = ra_s;
                        rout_en_s  = 1'b1;
                        OutPortin  = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            ST_E1: begin
                case (cls_s)
                    CL_RTYPE, CL_MULDIV: begin
                        rout_sel_s = (cls_s == CL_RTYPE) ? rc_s : rb_s;
                        rout_en_s  = 1'b1;
                        alu_s      = opcode_s;
                        ZLowIn     = 1'b1;
                        ZHighIn    = 1'b1;
                    end
                    CL_IMM: begin
                        CSignOut = 1'b1;
                        alu_s    = opcode_s;
                        ZLowIn   = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        CSignOut = 1'b1;
                        alu_s    = OP_ADD;
                        ZLowIn   = 1'b1;
                    end
                    CL_UNARY: begin
                        Zlowout  = 1'b1;
                        rin_en_s = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E2: begin
                case (cls_s)
                    CL_RTYPE, CL_IMM: begin
                        Zlowout  = 1'b1;
                        rin_en_s = 1'b1;
                    end
                    CL_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        Zlowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E3: begin
                case (cls_s)
                    CL_MULDIV: begin
                        Zhighout = 1'b1;
                        HIin     = 1'b1;
                    end
                    CL_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end
                    CL_ST: begin
                        rout_sel_s = ra_s;
                        rout_en_s  = 1'b1;
                        MDRin      = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E4: begin
                case (cls_s)
                    CL_LD: begin
                        MDRout   = 1'b1;
                        rin_en_s = 1'b1;
                    end
                    CL_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_op = OPW'(alu_s);

    reg_select_decoder u_rout_dec (
        .sel_i    (rout_sel_s),
        .en_i     (rout_en_s),
        .onehot_o (Rout)
    );

    // Destination register is always the Ra field
    reg_select_decoder u_rin_dec (
        .sel_i    (ra_s),
        .en_i     (rin_en_s),
        .onehot_o (Rin)
    );

    control_sequencer_checker u_checker (
        .clock     (clock),
        .clear     (clear),
        .bus_sel_i ({PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout,
                     InPortout, CSignOut, Rout})
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-instruction micro-op model expands each
// instruction into expected per-cycle outputs, compared against the DUT every cycle.
module tb_control_sequencer;
    import control_pkg::*;

    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic        pcout, zhighout, zlowout, mdrout, hiout, loout, yout, inportout, csignout;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        marin, pcin, mdrin, irin, yin, hiin, loin, zhighin, zlowin, incpc, read, write;
        logic [4:0]  alu_op;
        logic        run;
        logic        illegal;
        logic        outportin;
    } ctl_t;

    typedef struct packed {
        ctl_t        exp;
        logic        rdy;
        logic [31:0] ir;
        logic        clr;
    } step_t;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, CSignOut;
    logic [15:0] Rout, Rin;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write;
    logic [4:0]  alu_op;
    logic        run, illegal;
    logic        outportin_s;
    ctl_t        obs_s;

    step_t steps[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    always #5 clock = ~clock;

    control_sequencer #(.MEM_WAIT_MAX(WAIT_MAX), .OPW(5)) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Yout(Yout), .InPortout(InPortout),
        .CSignOut(CSignOut), .Rout(Rout), .Rin(Rin), .MARin(MARin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read), .Write(Write),
`ifdef SEQ_IO_INSTR_EN
        .OutPortin(outportin_s),
`endif
        .alu_op(alu_op), .run(run), .illegal(illegal)
    );

`ifndef SEQ_IO_INSTR_EN
    assign outportin_s = 1'b0;
`endif

    assign obs_s = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, CSignOut,
                    Rout, Rin, MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
                    IncPC, Read, Write, alu_op, run, illegal, outportin_s};

    function automatic ctl_t idle();
        ctl_t c;
        c     = '0;
        c.run = 1'b1;
        return c;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        return 16'h0001 << n;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h5a5a};
    endfunction

    function automatic bit legal(input logic [4:0] op);
        bit ok;
        ok = (op <= 5'h11) || (op == OP_NOP) || (op == OP_HALT);
`ifdef SEQ_IO_INSTR_EN
        ok = ok || (op == OP_IN) || (op == OP_OUT);
`endif
        return ok;
    endfunction

    task automatic push(input ctl_t c, input logic rdy, input logic [31:0] ir, input logic clr);
        step_t s;
        s.exp = c;
        s.rdy = rdy;
        s.ir  = ir;
        s.clr = clr;
        steps.push_back(s);
    endtask

    // A stopped state held n cycles, then clear for one cycle, then one cycle in RESET.
    task automatic hold_stopped(input logic [31:0] ir, input int n);
        repeat (n) push('0, rnd(), ir, 1'b0);
        push('0, rnd(), ir, 1'b1);
        push('0, rnd(), ir, 1'b0);
    endtask

    task automatic mem_wait(input ctl_t c, input logic [31:0] ir, input int dly, output bit faulted);
        faulted = 1'b0;
        if (dly < 0) begin
            repeat (WAIT_MAX) push(c, 1'b0, ir, 1'b0);
            faulted = 1'b1;
        end else begin
            repeat (dly) push(c, 1'b0, ir, 1'b0);
            push(c, 1'b1, ir, 1'b0);
        end
    endtask

    // Expand one instruction into its expected cycle-by-cycle control words.
    task automatic run_instr(input logic [31:0] ir, input int fdly, input int mdly);
        ctl_t       c;
        bit         f;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ir[31:27];
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        c = idle(); c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1;
        push(c, rnd(), ir, 1'b0);
        c = idle(); c.read = 1'b1; c.mdrin = 1'b1;
        mem_wait(c, ir, fdly, f);
        if (f) begin
            hold_stopped(ir, 4);
            return;
        end
        c = idle(); c.mdrout = 1'b1; c.irin = 1'b1;
        push(c, rnd(), ir, 1'b0);
        c = idle(); c.illegal = !legal(op);
        push(c, rnd(), ir, 1'b0);
        if (!legal(op) || op == OP_NOP) begin
            return;
        end else if (op == OP_HALT) begin
            hold_stopped(ir, 20);
        end else if (op <= OP_ORI) begin
            c = idle(); c.rout = oh(rb); c.yin = 1'b1; push(c, rnd(), ir, 1'b0);
            c = idle(); c.alu_op = op; c.zlowin = 1'b1;
            if (op <= OP_ROL) begin
                c.rout = oh(rc); c.zhighin = 1'b1;
            end else begin
                c.csignout = 1'b1;
            end
            push(c, rnd(), ir, 1'b0);
            c = idle(); c.zlowout = 1'b1; c.rin = oh(ra); push(c, rnd(), ir, 1'b0);
        end else if (op == OP_MUL || op == OP_DIV) begin
            c = idle(); c.rout = oh(ra); c.yin = 1'b1; push(c, rnd(), ir, 1'b0);
            c = idle(); c.rout = oh(rb); c.alu_op = op; c.zlowin = 1'b1; c.zhighin = 1'b1;
            push(c, rnd(), ir, 1'b0);
            c = idle(); c.zlowout = 1'b1; c.loin = 1'b1; push(c, rnd(), ir, 1'b0);
            c = idle(); c.zhighout = 1'b1; c.hiin = 1'b1; push(c, rnd(), ir, 1'b0);
        end else if (op == OP_NEG || op == OP_NOT) begin
            c = idle(); c.rout = oh(rb); c.alu_op = op; c.zlowin = 1'b1; push(c, rnd(), ir, 1'b0);
            c = idle(); c.zlowout = 1'b1; c.rin = oh(ra); push(c, rnd(), ir, 1'b0);
        end else if (op == OP_LD || op == OP_ST) begin
            c = idle(); c.rout = oh(rb); c.yin = 1'b1; push(c, rnd(), ir, 1'b0);
            c = idle(); c.csignout = 1'b1; c.alu_op = 5'h00; c.zlowin = 1'b1; push(c, rnd(), ir, 1'b0);
            c = idle(); c.zlowout = 1'b1; c.marin = 1'b1; push(c, rnd(), ir, 1'b0);
            if (op == OP_LD) begin
                c = idle(); c.read = 1'b1; c.mdrin = 1'b1;
                mem_wait(c, ir, mdly, f);
                if (f) begin
                    hold_stopped(ir, 4);
                    return;
                end
                c = idle(); c.mdrout = 1'b1; c.rin = oh(ra); push(c, rnd(), ir, 1'b0);
            end else begin
                c = idle(); c.rout = oh(ra); c.mdrin = 1'b1; push(c, rnd(), ir, 1'b0);
                c = idle(); c.write = 1'b1;
                mem_wait(c, ir, mdly, f);
                if (f) hold_stopped(ir, 4);
            end
        end else if (op == OP_IN) begin
            c = idle(); c.inportout = 1'b1; c.rin = oh(ra); push(c, rnd(), ir, 1'b0);
        end else begin
            c = idle(); c.rout = oh(ra); c.outportin = 1'b1; push(c, rnd(), ir, 1'b0);
        end
    endtask

    // Clear asserted for two cycles while the fetch read is still waiting.
    task automatic fetch_abort(input logic [31:0] ir, input int nwait);
        ctl_t c;
        c = idle(); c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1;
        push(c, rnd(), ir, 1'b0);
        c = idle(); c.read = 1'b1; c.mdrin = 1'b1;
        repeat (nwait) push(c, 1'b0, ir, 1'b0);
        push(c, 1'b0, ir, 1'b1);
        push('0, 1'b0, ir, 1'b1);
        push('0, rnd(), ir, 1'b0);
    endtask

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL model_%s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        int b;
        int nread;
        clear     = 1'b1;
        mem_ready = 1'b0;
        IR        = 32'h0000_0000;

        push('0, 1'b0, 32'h0000_0000, 1'b0);
        fetch_abort(mk(OP_ADD, 4'd3, 4'd1, 4'd2), 10);

        b = steps.size();
        run_instr(mk(OP_ADD, 4'd3, 4'd1, 4'd2), 14, 0);
        pin("add_len", 32'(steps.size() - b), 32'd21);
        pin("add_e0_rout", 32'(steps[b+18].exp.rout), 32'h0002);
        pin("add_e1_rout", 32'(steps[b+19].exp.rout), 32'h0004);
        pin("add_e1_alu", 32'(steps[b+19].exp.alu_op), 32'h0);
        pin("add_e2_rin", 32'(steps[b+20].exp.rin), 32'h0008);

        b = steps.size();
        run_instr(mk(OP_SUB, 4'd5, 4'd6, 4'd7), 0, 0);
        pin("sub_cpi", 32'(steps.size() - b), 32'd7);
        run_instr(mk(OP_ROR, 4'd15, 4'd0, 4'd14), 2, 0);
        run_instr(mk(OP_ADDI, 4'd2, 4'd4, 4'd0), 0, 0);
        run_instr(mk(OP_ORI, 4'd9, 4'd8, 4'd1), 1, 0);

        b = steps.size();
        run_instr(mk(OP_NEG, 4'd6, 4'd11, 4'd0), 0, 0);
        pin("neg_cpi", 32'(steps.size() - b), 32'd6);
        run_instr(mk(OP_NOT, 4'd0, 4'd15, 4'd0), 0, 0);

        b = steps.size();
        run_instr(mk(OP_MUL, 4'd1, 4'd2, 4'd0), 0, 0);
        pin("mul_cpi", 32'(steps.size() - b), 32'd8);
        pin("mul_e2_lo", 32'({steps[b+6].exp.zlowout, steps[b+6].exp.loin}), 32'h3);
        pin("mul_e3_hi", 32'({steps[b+7].exp.zhighout, steps[b+7].exp.hiin}), 32'h3);
        run_instr(mk(OP_DIV, 4'd12, 4'd13, 4'd0), 0, 0);

        b = steps.size();
        run_instr(mk(OP_LD, 4'd1, 4'd4, 4'd0), 0, 3);
        nread = 0;
        for (int i = b + 7; i < steps.size(); i++) nread += int'(steps[i].exp.read);
        pin("ld_len", 32'(steps.size() - b), 32'd12);
        pin("ld_read_cycles", 32'(nread), 32'd4);
        pin("ld_e4_rin", 32'(steps[steps.size()-1].exp.rin), 32'h0002);

        run_instr(mk(OP_ST, 4'd7, 4'd3, 4'd0), 0, 0);
        run_instr(mk(OP_LD, 4'd10, 4'd5, 4'd0), 0, 14);
        run_instr(mk(OP_NOP, 4'd0, 4'd0, 4'd0), 0, 0);

        b = steps.size();
        run_instr(mk(5'h1F, 4'd0, 4'd0, 4'd0), 0, 0);
        pin("illegal_len", 32'(steps.size() - b), 32'd4);
        pin("illegal_t3", 32'(steps[b+3].exp.illegal), 32'h1);
        run_instr(mk(5'h14, 4'd2, 4'd2, 4'd2), 0, 0);
        run_instr(mk(OP_IN, 4'd4, 4'd0, 4'd0), 0, 0);
        run_instr(mk(OP_OUT, 4'd8, 4'd0, 4'd0), 0, 0);
        run_instr(mk(OP_HALT, 4'd0, 4'd0, 4'd0), 0, 0);

        b = steps.size();
        run_instr(mk(OP_ST, 4'd2, 4'd1, 4'd0), 0, -1);
        pin("st_fault_len", 32'(steps.size() - b), 32'd8 + 32'(WAIT_MAX) + 32'd6);
        run_instr(mk(OP_AND, 4'd14, 4'd13, 4'd12), 0, 0);

        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < steps.size(); i++) begin
            IR        = steps[i].ir;
            mem_ready = steps[i].rdy;
            clear     = steps[i].clr;
            @(negedge clock);
            tests_run++;
            if (obs_s !== steps[i].exp) begin
                tests_failed++;
                $display("FAIL step%0d ctl: got %h expected %h (ir=%h)", i, obs_s, steps[i].exp, steps[i].ir);
            end
            @(posedge clock);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
